pc_seq_unit: RTL
================

Name: pc_seq_unit

Overview:
- Parametrised program-counter sequencer for the basic_proc fetch stage; next generation of the single-register PC.
- Adds selectable per-program start vectors, signed relative and absolute branches, and call/return through an internal return-address stack (RAS).
- Adds stall and halt handling.
- Drives instruction-ROM address; control decoder supplies Op/Target, ALU supplies CmpFlag.

Parameters:
- PC_W, 10, program counter width (10..32)
- TGT_W, 9, branch target field width (TGT_W <= PC_W)
- RAS_DEPTH, 4, return-address stack entries (>=1)
- NUM_PROG, 3, number of selectable program start vectors (>=1)

Ports:
- Clk  input  1  clock; all state changes on posedge only
- Reset  input  1  synchronous, active-high reset
- Start  input  1  testbench start request; PC held at start vector while high
- ProgSel  input  $clog2(NUM_PROG) (min 1)  selects start vector
- StartVec  input  NUM_PROG x PC_W  packed start addresses, index = program number
- Stall  input  1  hold PC and RAS this cycle
- Op  input  3  sequencing op (encodings in package)
- Target  input  TGT_W  branch offset (signed) or absolute target (unsigned)
- CmpFlag  input  1  condition from ALU
- ProgCtr  output  PC_W  registered program counter
- Halted  output  1  registered; high after HALT executed
- RasCount  output  $clog2(RAS_DEPTH+1)  current stack occupancy
- RasOvf  output  1  sticky: CALL on full stack
- RasUnf  output  1  sticky: RET on empty stack

Behaviour:
- Reset: Reset is synchronous, active-high; clock is Clk.
  - ProgCtr=StartVec[0]; Halted=0; RasCount=0; RasOvf=0; RasUnf=0.
- Priority per edge: Reset > Start > Halted > Stall > Op.
- Start high:
  - ProgCtr <= StartVec[ProgSel]; ProgSel >= NUM_PROG uses index 0.
  - RAS emptied; Halted, RasOvf, RasUnf cleared.
  - Held every cycle Start is high; execution begins the first edge after Start falls.
- Halted=1: all state held; Op/Stall ignored until Start or Reset.
- Stall=1 (not halted): ProgCtr, RAS and flags unchanged.
- Ops (take effect at next posedge, single-cycle latency; arithmetic modulo 2^PC_W):
  - OP_INC (0): PC <= PC+1.
  - OP_BRREL (1): if CmpFlag, PC <= PC + sext(Target); else PC+1.
  - OP_BRABS (2): if CmpFlag, PC <= zext(Target); else PC+1. Unconditional use: decoder drives CmpFlag=1.
  - OP_CALL (3): unconditional.
    - Push PC+1; PC <= zext(Target).
    - If RasCount==RAS_DEPTH: push dropped (stack contents unchanged), jump still taken, RasOvf<=1.
  - OP_RET (4):
    - If RasCount>0: PC <= top entry, pop.
    - If empty: PC <= PC+1, RasUnf<=1.
  - OP_HALT (5): PC held; Halted<=1 next edge.
  - 6,7: reserved, treated as OP_INC.
- RAS: LIFO stack with pointer; no simultaneous push/pop (one op per cycle). Count saturates at 0 and RAS_DEPTH.
- Wrap: PC=2^PC_W-1 with OP_INC gives 0; relative branches wrap both directions.
- Reset mid-CALL/RET: the reset result wins and no push/pop occurs.

Decomposition:
- Package pc_seq_pkg:
  - typedef enum logic [2:0] op_t {OP_INC, OP_BRREL, OP_BRABS, OP_CALL, OP_RET, OP_HALT}.
  - Default parameter constants.
- Sub-module ras_stack (params DEPTH, W):
  - Ports: push, pop, push_data, top, count, full, empty.
  - Synchronous clear.
  - Instantiated once.
- Next-PC mux stays in pc_seq_unit.

Test Plan:
- Reset, then Start=1 with ProgSel=2, StartVec={2:0x100, 1:0x080, 0:0x000} for 3 cycles, release, 3x OP_INC -> ProgCtr 0x100 held during Start, then 0x101, 0x102, 0x103.
- PC=0x010, OP_BRREL Target=9'h1F6 (-10) with CmpFlag=1 -> 0x006. Same op with CmpFlag=0 -> 0x011. PC=0x3FF, OP_INC -> 0x000.
- Nested calls at PC 0x020 (Target 0x050) and 0x051 (Target 0x070), then RET, RET -> PC 0x050, 0x070, 0x052, 0x021. RasCount 1,2,1,0.
- 5 CALLs with RAS_DEPTH=4 -> RasOvf=1 after 5th, jump taken, RasCount=4. 5 RETs -> first 4 return addresses in LIFO order, 5th increments PC and sets RasUnf=1.
- Stall=1 with OP_CALL for 2 cycles -> PC and RasCount unchanged. Stall=0 -> call executes once.
- OP_HALT at 0x030 -> Halted=1, PC stays 0x030 under any Op. Start pulse -> Halted=0, PC=StartVec[ProgSel], flags cleared.

Source files
------------

// File: rtl/pc_seq_unit_pkg.sv
// Shared types and default sizing for the basic_proc program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_INC   = 3'd0,
        OP_BRREL = 3'd1,
        OP_BRABS = 3'd2,
        OP_CALL  = 3'd3,
        OP_RET   = 3'd4,
        OP_HALT  = 3'd5
    } op_t;

    localparam int PC_W_DEF      = 10;
    localparam int TGT_W_DEF     = 9;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int NUM_PROG_DEF  = 3;

    // A select field is never narrower than one bit, even for a single program.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Sequencer control/status bundle between the decoder side and the PC sequencer.
interface pc_seq_unit_if
    import pc_seq_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int TGT_W     = TGT_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int NUM_PROG  = NUM_PROG_DEF
);
    localparam int PS_W = sel_w(NUM_PROG);
    localparam int RC_W = $clog2(RAS_DEPTH + 1);

    logic                     Start;
    logic [PS_W-1:0]          ProgSel;
    logic [NUM_PROG*PC_W-1:0] StartVec;
    logic                     Stall;
    logic [2:0]               Op;
    logic [TGT_W-1:0]         Target;
    logic                     CmpFlag;
    logic [PC_W-1:0]          ProgCtr;
    logic                     Halted;
    logic [RC_W-1:0]          RasCount;
    logic                     RasOvf;
    logic                     RasUnf;

    modport master (
        output Start, ProgSel, StartVec, Stall, Op, Target, CmpFlag,
        input  ProgCtr, Halted, RasCount, RasOvf, RasUnf
    );

    modport slave (
        input  Start, ProgSel, StartVec, Stall, Op, Target, CmpFlag,
        output ProgCtr, Halted, RasCount, RasOvf, RasUnf
    );

endinterface

// File: rtl/pc_seq_unit_ras_stack.sv
// Return-address LIFO; pushes on a full stack and pops on an empty one are ignored.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_mem [DEPTH];

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == {CW{1'b0}});
    assign count = r_count;

    // Occupancy pointer, saturating at both ends.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_count <= {CW{1'b0}};
        end else if (push && !full) begin
            r_count <= r_count + CW'(1'b1);
        end else if (pop && !empty) begin
            r_count <= r_count - CW'(1'b1);
        end
    end

    // Entry write at the current pointer.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && !Clr && (r_count == CW'(i))) begin
                r_mem[i] <= push_data;
            end
        end
    end

    // Top-of-stack read; zero when empty.
    always_comb begin
        top = {W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            top = (r_count == CW'(i + 1)) ? r_mem[i] : top;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: start vectors, relative/absolute branches, call/return, stall, halt.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int TGT_W     = TGT_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int NUM_PROG  = NUM_PROG_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    pc_seq_unit_if.slave io_seq
);
    localparam int RC_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0] r_pc;
    logic            r_halted;
    logic            r_ovf;
    logic            r_unf;

    logic [PC_W-1:0] w_pc_inc, w_rel, w_abs, w_start_pc, w_next_pc, w_ras_top;
    logic [RC_W-1:0] w_ras_count;
    logic            w_exec, w_clr, w_push, w_pop, w_full, w_empty;
    logic            w_set_ovf, w_set_unf, w_set_halt;

    assign w_pc_inc = r_pc + PC_W'(1'b1);
    assign w_rel    = r_pc + PC_W'($signed(io_seq.Target));
    assign w_abs    = PC_W'(io_seq.Target);
    assign w_exec   = !Reset && !io_seq.Start && !r_halted && !io_seq.Stall;
    assign w_clr    = Reset || io_seq.Start;

    // Start-vector select; out-of-range program numbers fall back to program 0.
    always_comb begin
        w_start_pc = io_seq.StartVec[PC_W-1:0];
        for (int i = 1; i < NUM_PROG; i++) begin
            w_start_pc = (int'(io_seq.ProgSel) == i) ? io_seq.StartVec[i*PC_W +: PC_W] : w_start_pc;
        end
    end

    // Next-PC mux and stack/flag requests for the current op.
    always_comb begin
        w_next_pc  = w_pc_inc;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
        w_set_halt = 1'b0;
        case (op_t'(io_seq.Op))
            OP_INC:   w_next_pc = w_pc_inc;
            OP_BRREL: w_next_pc = io_seq.CmpFlag ? w_rel : w_pc_inc;
            OP_BRABS: w_next_pc = io_seq.CmpFlag ? w_abs : w_pc_inc;
            OP_CALL: begin
                w_next_pc = w_abs;
                w_push    = w_exec;
                w_set_ovf = w_full;
            end
            OP_RET: begin
                if (!w_empty) begin
                    w_next_pc = w_ras_top;
                    w_pop     = w_exec;
                end else begin
                    w_next_pc = w_pc_inc;
                    w_set_unf = 1'b1;
                end
            end
            OP_HALT: begin
                w_next_pc  = r_pc;
                w_set_halt = 1'b1;
            end
            default: w_next_pc = w_pc_inc;
        endcase
    end

    // PC and status registers; halt and stall simply leave everything as is.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc     <= io_seq.StartVec[PC_W-1:0];
            r_halted <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (io_seq.Start) begin
            r_pc     <= w_start_pc;
            r_halted <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (w_exec) begin
            r_pc     <= w_next_pc;
            r_halted <= w_set_halt;
            r_ovf    <= r_ovf | w_set_ovf;
            r_unf    <= r_unf | w_set_unf;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .Clk       (Clk),
        .Clr       (w_clr),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_ras_top),
        .count     (w_ras_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign io_seq.ProgCtr  = r_pc;
    assign io_seq.Halted   = r_halted;
    assign io_seq.RasCount = w_ras_count;
    assign io_seq.RasOvf   = r_ovf;
    assign io_seq.RasUnf   = r_unf;

endmodule
